// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: two-master (display reader, CPU writer), one-slave arbiter
// for the framebuffer port, all in the pixel clock domain.
// Optional feature: define VGA_ARB_STARVE_GUARD_EN to bound how long the CPU
// can be kept off the port by a display that never releases it.
module vga_mem_arbiter #(
  parameter int unsigned AW            = 32,
  parameter int unsigned DW            = 32,
  parameter int unsigned CPU_BURST_MAX = 16,
  parameter int unsigned STARVE_LIMIT  = 256
) (
  input  logic            pixel_clk,
  input  logic            pixel_rst_n,
  // display line reader
  input  logic            vid_req,
  input  logic [AW-1:0]   vid_adr,
  output logic            vid_gnt,
  output logic            vid_ack,
  // CPU / pattern writer
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [AW-1:0]   cpu_adr,
  input  logic [DW-1:0]   cpu_dat_w,
  input  logic [DW/8-1:0] cpu_sel,
  output logic            cpu_gnt,
  output logic            cpu_ack,
  // slave bus
  output logic            mem_cyc,
  output logic            mem_stb,
  output logic            mem_we,
  output logic [AW-1:0]   mem_adr,
  output logic [DW-1:0]   mem_dat_w,
  output logic [DW/8-1:0] mem_sel,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_dat_r,
  output logic [DW-1:0]   dat_r
);

  localparam int unsigned BW = $clog2(CPU_BURST_MAX + 1);

  // Encoding puts each grant directly on a state flop: bit0 = display, bit1 = CPU.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_VID  = 2'b01,
    ST_CPU  = 2'b10
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [BW-1:0] beat_cnt;
  logic          beat_last_c;
  logic          cpu_starved_c;

  // Reject parameter values that make the burst limit meaningless.
  if (CPU_BURST_MAX < 1 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("vga_mem_arbiter: CPU_BURST_MAX and STARVE_LIMIT must be at least 1");
  end

  // Current ack is the CPU_BURST_MAX-th of this tenure (count saturates there).
  assign beat_last_c = (beat_cnt >= BW'(CPU_BURST_MAX - 1));

`ifdef VGA_ARB_STARVE_GUARD_EN
  localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);

  logic [SCW-1:0] starve_cnt;

  // Cycles the CPU has waited while the display owns the port.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE && state_nxt == ST_CPU) begin
      starve_cnt <= '0;
    end else if (state == ST_VID && cpu_req && starve_cnt != SCW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + SCW'(1);
    end
  end

  assign cpu_starved_c = (starve_cnt == SCW'(STARVE_LIMIT));
`else
  assign cpu_starved_c = 1'b0;
`endif

  // State register; grants fall asynchronously with reset.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: display priority, CPU burst cap, starvation override.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (cpu_req && cpu_starved_c) begin
          state_nxt = ST_CPU;
        end else if (vid_req) begin
          state_nxt = ST_VID;
        end else if (cpu_req) begin
          state_nxt = ST_CPU;
        end
      end
      ST_VID: begin
        if (!vid_req) begin
          state_nxt = ST_IDLE;
        end else if (mem_ack && cpu_starved_c) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CPU: begin
        if (!cpu_req) begin
          state_nxt = ST_IDLE;
        end else if (mem_ack && vid_req && beat_last_c) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // CPU beats completed in the current tenure; idle clears it before each entry.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      beat_cnt <= '0;
    end else if (state == ST_IDLE) begin
      beat_cnt <= '0;
    end else if (state == ST_CPU && mem_ack && beat_cnt != BW'(CPU_BURST_MAX)) begin
      beat_cnt <= beat_cnt + BW'(1);
    end
  end

  assign vid_gnt = state[0];
  assign cpu_gnt = state[1];
  assign vid_ack = mem_ack & vid_gnt;
  assign cpu_ack = mem_ack & cpu_gnt;
  assign dat_r   = mem_dat_r;

  // Slave bus mux selected by the registered grants; all zeros when idle.
  always_comb begin
    mem_cyc   = 1'b0;
    mem_stb   = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_dat_w = '0;
    mem_sel   = '0;
    if (vid_gnt) begin
      mem_cyc = 1'b1;
      mem_stb = vid_req;
      mem_sel = '1;
      mem_adr = vid_adr;
    end else if (cpu_gnt) begin
      mem_cyc   = 1'b1;
      mem_stb   = cpu_req;
      mem_we    = cpu_we;
      mem_adr   = cpu_adr;
      mem_dat_w = cpu_dat_w;
      mem_sel   = cpu_sel;
    end
  end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter (builds with or without VGA_ARB_STARVE_GUARD_EN).
module tb_vga_mem_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SW   = DW / 8;
  localparam int unsigned BMAX = 16;
  localparam int unsigned SLIM = 8;

  logic          pixel_clk = 1'b0;
  logic          pixel_rst_n;
  logic          vid_req;
  logic [AW-1:0] vid_adr;
  logic          vid_gnt;
  logic          vid_ack;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_dat_w;
  logic [SW-1:0] cpu_sel;
  logic          cpu_gnt;
  logic          cpu_ack;
  logic          mem_cyc;
  logic          mem_stb;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_dat_w;
  logic [SW-1:0] mem_sel;
  logic          mem_ack;
  logic [DW-1:0] mem_dat_r;
  logic [DW-1:0] dat_r;

  logic slave_en;
  logic slave_ack;
  logic man_ack;

  int n_checks = 0;
  int n_fail   = 0;

  vga_mem_arbiter #(
    .AW(AW), .DW(DW), .CPU_BURST_MAX(BMAX), .STARVE_LIMIT(SLIM)
  ) dut (
    .pixel_clk  (pixel_clk),
    .pixel_rst_n(pixel_rst_n),
    .vid_req    (vid_req),
    .vid_adr    (vid_adr),
    .vid_gnt    (vid_gnt),
    .vid_ack    (vid_ack),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_adr    (cpu_adr),
    .cpu_dat_w  (cpu_dat_w),
    .cpu_sel    (cpu_sel),
    .cpu_gnt    (cpu_gnt),
    .cpu_ack    (cpu_ack),
    .mem_cyc    (mem_cyc),
    .mem_stb    (mem_stb),
    .mem_we     (mem_we),
    .mem_adr    (mem_adr),
    .mem_dat_w  (mem_dat_w),
    .mem_sel    (mem_sel),
    .mem_ack    (mem_ack),
    .mem_dat_r  (mem_dat_r),
    .dat_r      (dat_r)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Slave: one wait state per beat; read data tags the address.
  always @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) slave_ack <= 1'b0;
    else              slave_ack <= slave_en & mem_stb & ~slave_ack;
  end

  assign mem_ack   = slave_ack | man_ack;
  assign mem_dat_r = {16'hD000, mem_adr[15:0]};

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge pixel_clk);
    pixel_rst_n = 1'b0;
    vid_req = 1'b0; cpu_req = 1'b0; man_ack = 1'b0; slave_en = 1'b0;
    @(negedge pixel_clk);
    pixel_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pixel_rst_n = 1'b0;
    vid_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
    vid_adr = 32'hA000_0040; cpu_adr = 32'h0000_0200;
    cpu_dat_w = 32'h1234_5678; cpu_sel = 4'hF;
    man_ack = 1'b1; slave_en = 1'b0;
    repeat (2) @(posedge pixel_clk);
    @(negedge pixel_clk);
    n_checks++;
    if ({vid_gnt, cpu_gnt, mem_cyc, mem_stb, mem_we, vid_ack, cpu_ack} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {vid_gnt, cpu_gnt, mem_cyc, mem_stb, mem_we, vid_ack, cpu_ack});
    end
    n_checks++;
    if ({mem_adr, mem_dat_w, mem_sel} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_bus: adr %h dat %h sel %h expected all zero", mem_adr, mem_dat_w, mem_sel);
    end
    man_ack = 1'b0;
    pixel_rst_n = 1'b1;
    tick();
    n_checks++;
    if ({vid_gnt, cpu_gnt, mem_cyc, mem_stb, mem_we} !== 5'b10110) begin
      n_fail++;
      $display("FAIL reset_first_grant: vid_gnt/cpu_gnt/cyc/stb/we %b expected 10110",
               {vid_gnt, cpu_gnt, mem_cyc, mem_stb, mem_we});
    end
    n_checks++;
    if ({mem_adr, mem_sel} !== {32'hA000_0040, 4'hF}) begin
      n_fail++;
      $display("FAIL reset_vid_bus: adr %h sel %h expected a0000040 f", mem_adr, mem_sel);
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    tick();
    n_checks++;
    if ({mem_cyc, vid_gnt, cpu_gnt} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release_idle: cyc/vid_gnt/cpu_gnt %b expected 000", {mem_cyc, vid_gnt, cpu_gnt});
    end
  endtask

  task automatic test_idle_ack();
    @(negedge pixel_clk);
    man_ack = 1'b1;
    #1;
    n_checks++;
    if ({vid_ack, cpu_ack} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_ack: vid_ack/cpu_ack %b expected 00", {vid_ack, cpu_ack});
    end
    tick();
    man_ack = 1'b0;
    n_checks++;
    if (mem_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ack_state: mem_cyc %b expected 0", mem_cyc);
    end
  endtask

  task automatic test_cpu_writes();
    logic [AW-1:0] adrs [3];
    int acks;
    adrs[0] = 32'h10; adrs[1] = 32'h14; adrs[2] = 32'h18;
    acks = 0;
    slave_en = 1'b1; cpu_we = 1'b1; cpu_sel = 4'hF;
    cpu_adr = adrs[0]; cpu_dat_w = 32'hC0DE_0000; cpu_req = 1'b1;
    for (int cyc = 0; cyc < 40 && acks < 3; cyc++) begin
      @(negedge pixel_clk);
      if (cpu_ack) begin
        n_checks++;
        if ({mem_we, mem_adr, mem_dat_w, mem_sel} !== {1'b1, adrs[acks], 32'hC0DE_0000 + 32'(acks), 4'hF}) begin
          n_fail++;
          $display("FAIL cpu_write_beat%0d: we %b adr %h dat %h sel %h expected 1 %h %h f",
                   acks, mem_we, mem_adr, mem_dat_w, mem_sel, adrs[acks], 32'hC0DE_0000 + 32'(acks));
        end
        acks++;
        tick();
        if (acks < 3) begin
          cpu_adr = adrs[acks];
          cpu_dat_w = 32'hC0DE_0000 + 32'(acks);
        end else begin
          cpu_req = 1'b0;
        end
      end else begin
        tick();
      end
    end
    n_checks++;
    if (acks != 3) begin
      n_fail++;
      $display("FAIL cpu_write_count: %0d acks expected 3", acks);
    end
    @(negedge pixel_clk);
    n_checks++;
    if ({mem_cyc, mem_stb, cpu_gnt} !== 3'b101) begin
      n_fail++;
      $display("FAIL cpu_req_drop: cyc/stb/gnt %b expected 101", {mem_cyc, mem_stb, cpu_gnt});
    end
    tick();
    n_checks++;
    if ({mem_cyc, cpu_gnt, mem_we, mem_adr} !== 35'h0) begin
      n_fail++;
      $display("FAIL cpu_end_idle: cyc %b gnt %b we %b adr %h expected all zero", mem_cyc, cpu_gnt, mem_we, mem_adr);
    end
  endtask

  task automatic test_preempt();
    int cb, vb, ack16, vg_first, cb_at_vg, vdrop, regain, overlap;
    logic [2:0] idle16;
    bit ca, va;
    cb = 0; vb = 0; ack16 = -1; vg_first = -1; cb_at_vg = -1;
    vdrop = -1; regain = -1; overlap = 0; idle16 = 3'b111;
    slave_en = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h0000_1000;
    vid_adr = 32'h0008_0000; vid_req = 1'b0; cpu_req = 1'b1;
    for (int cyc = 0; cyc < 300 && cb < 40; cyc++) begin
      @(negedge pixel_clk);
      ca = cpu_ack; va = vid_ack;
      if (vid_gnt && cpu_gnt) overlap++;
      if (ack16 >= 0 && cyc == ack16 + 1) idle16 = {mem_cyc, vid_gnt, cpu_gnt};
      if (vg_first < 0 && vid_gnt) begin vg_first = cyc; cb_at_vg = cb; end
      if (vdrop >= 0 && regain < 0 && cpu_gnt) regain = cyc;
      tick();
      if (ca) begin
        cb++;
        cpu_adr = cpu_adr + 32'd4;
        if (cb == 5) vid_req = 1'b1;
        if (cb == 16) ack16 = cyc;
        if (cb == 40) cpu_req = 1'b0;
      end
      if (va) begin
        vb++;
        vid_adr = vid_adr + 32'd4;
        if (vb == 3) begin vid_req = 1'b0; vdrop = cyc; end
      end
    end
    n_checks++;
    if (cb != 40) begin n_fail++; $display("FAIL preempt_total: %0d cpu beats expected 40", cb); end
    n_checks++;
    if (cb_at_vg != 16) begin n_fail++; $display("FAIL preempt_beats: %0d cpu beats before display grant expected 16", cb_at_vg); end
    n_checks++;
    if (idle16 !== 3'b000) begin n_fail++; $display("FAIL preempt_gap: cyc/vid_gnt/cpu_gnt %b expected 000", idle16); end
    n_checks++;
    if (ack16 < 0 || vg_first != ack16 + 2) begin
      n_fail++; $display("FAIL preempt_latency: vid_gnt at %0d expected %0d", vg_first, ack16 + 2);
    end
    n_checks++;
    if (vdrop < 0 || regain != vdrop + 3) begin
      n_fail++; $display("FAIL preempt_regain: cpu_gnt at %0d expected %0d", regain, vdrop + 3);
    end
    n_checks++;
    if (overlap != 0 || vb != 3) begin
      n_fail++; $display("FAIL preempt_vid: overlap %0d vid beats %0d expected 0 and 3", overlap, vb);
    end
    repeat (2) tick();
  endtask

  task automatic test_handover();
    logic [AW-1:0] vadrs [2];
    int vb, gap, gnt_at;
    bit seen, done;
    vadrs[0] = 32'h0004_0100; vadrs[1] = 32'h0004_0104;
    vb = 0; gap = 0; gnt_at = -1; seen = 1'b0; done = 1'b0;
    slave_en = 1'b1; cpu_req = 1'b0; vid_adr = vadrs[0]; vid_req = 1'b1;
    for (int cyc = 0; cyc < 60 && vb < 2; cyc++) begin
      @(negedge pixel_clk);
      if (vid_ack) begin
        n_checks++;
        if ({mem_we, mem_sel, mem_adr, dat_r} !== {1'b0, 4'hF, vadrs[vb], 16'hD000, vadrs[vb][15:0]}) begin
          n_fail++;
          $display("FAIL vid_read_beat%0d: we %b sel %h adr %h dat_r %h expected 0 f %h d000%h",
                   vb, mem_we, mem_sel, mem_adr, dat_r, vadrs[vb], vadrs[vb][15:0]);
        end
        vb++;
        tick();
        if (vb < 2) vid_adr = vadrs[vb];
        else begin
          vid_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h0000_2000;
        end
      end else begin
        tick();
      end
    end
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge pixel_clk);
      if (cyc == 0) begin
        n_checks++;
        if ({vid_gnt, mem_cyc, mem_stb} !== 3'b110) begin
          n_fail++; $display("FAIL handover_tail: vid_gnt/cyc/stb %b expected 110", {vid_gnt, mem_cyc, mem_stb});
        end
      end
      if (cpu_gnt) begin seen = 1'b1; gnt_at = cyc; end
      else if (!mem_cyc) gap++;
      tick();
    end
    n_checks++;
    if (gap != 1 || gnt_at != 2) begin
      n_fail++; $display("FAIL handover_gap: %0d idle cycles, cpu_gnt at %0d expected 1 and 2", gap, gnt_at);
    end
    for (int cyc = 0; cyc < 10 && !done; cyc++) begin
      @(negedge pixel_clk);
      if (cpu_ack) begin
        done = 1'b1;
        n_checks++;
        if ({mem_we, mem_adr, dat_r} !== {1'b0, 32'h0000_2000, 32'hD000_2000}) begin
          n_fail++; $display("FAIL cpu_read: we %b adr %h dat_r %h expected 0 00002000 d0002000", mem_we, mem_adr, dat_r);
        end
      end
      tick();
    end
    cpu_req = 1'b0;
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL cpu_read_timeout: no cpu_ack expected one"); end
    repeat (2) tick();
  endtask

  task automatic test_starve();
    int vb, cg, cb, gnts;
    bit back;
    apply_reset();
    vb = 0; cg = -1; cb = 0; gnts = 0; back = 1'b0;
    slave_en = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h0000_3000; vid_adr = 32'h0000_0400;
    vid_req = 1'b1; cpu_req = 1'b1;
`ifdef VGA_ARB_STARVE_GUARD_EN
    for (int cyc = 0; cyc < 100 && cg < 0; cyc++) begin
      @(negedge pixel_clk);
      if (cpu_gnt) cg = cyc;
      else if (vid_ack) vb++;
    end
    n_checks++;
    if (cg < 0 || vb != 5) begin
      n_fail++; $display("FAIL starve_grant: cpu_gnt at %0d after %0d vid acks expected 5 acks", cg, vb);
    end
    for (int cyc = 0; cyc < 100 && !back; cyc++) begin
      @(negedge pixel_clk);
      if (vid_gnt) back = 1'b1;
      else if (cpu_ack) cb++;
    end
    n_checks++;
    if (!back || cb != 16) begin
      n_fail++; $display("FAIL starve_burst: %0d cpu beats, display back %b expected 16 and 1", cb, back);
    end
`else
    repeat (1000) begin
      @(negedge pixel_clk);
      if (cpu_gnt) gnts++;
      if (vid_ack) vb++;
    end
    n_checks++;
    if (gnts != 0) begin n_fail++; $display("FAIL strict_priority: cpu_gnt high %0d cycles expected 0", gnts); end
    n_checks++;
    if (vb != 500) begin n_fail++; $display("FAIL strict_vid_beats: %0d vid acks expected 500", vb); end
`endif
    vid_req = 1'b0; cpu_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_beat();
    bit granted;
    granted = 1'b0;
    slave_en = 1'b0; man_ack = 1'b0;
    cpu_we = 1'b1; cpu_adr = 32'h0000_5000; cpu_req = 1'b1;
    for (int cyc = 0; cyc < 10 && !granted; cyc++) begin
      @(negedge pixel_clk);
      if (cpu_gnt) granted = 1'b1;
    end
    #2;
    man_ack = 1'b1;
    #1;
    n_checks++;
    if ({granted, cpu_ack, mem_cyc} !== 3'b111) begin
      n_fail++; $display("FAIL midbeat_pre: granted/cpu_ack/cyc %b expected 111", {granted, cpu_ack, mem_cyc});
    end
    pixel_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_cyc, mem_stb, mem_we, cpu_gnt, cpu_ack, mem_adr} !== 37'h0) begin
      n_fail++; $display("FAIL midbeat_async: cyc %b stb %b we %b gnt %b ack %b adr %h expected all zero",
                         mem_cyc, mem_stb, mem_we, cpu_gnt, cpu_ack, mem_adr);
    end
    tick();
    n_checks++;
    if ({cpu_ack, vid_ack, cpu_gnt} !== 3'b000) begin
      n_fail++; $display("FAIL midbeat_ack_dropped: cpu_ack/vid_ack/gnt %b expected 000", {cpu_ack, vid_ack, cpu_gnt});
    end
    man_ack = 1'b0; cpu_req = 1'b0;
    @(negedge pixel_clk);
    pixel_rst_n = 1'b1;
    tick();
    n_checks++;
    if (mem_cyc !== 1'b0) begin n_fail++; $display("FAIL midbeat_recover: mem_cyc %b expected 0", mem_cyc); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pixel_rst_n = 1'b0;
    vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    vid_adr = '0; cpu_adr = '0; cpu_dat_w = '0; cpu_sel = '0;
    slave_en = 1'b0; man_ack = 1'b0;
    test_reset();
    test_idle_ack();
    test_cpu_writes();
    test_preempt();
    test_handover();
    test_starve();
    test_reset_mid_beat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
